// File: rtl/rggen_bit_field_set_arbiter_pkg.sv
// Shared types and constants for the bit-field set arbiter.
// Counter width applies only when RGGEN_SET_ARBITER_BLOCKED_COUNT_EN is defined.
package rggen_bit_field_set_arbiter_pkg;

   localparam int BLOCKED_COUNT_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } set_arb_state_e;

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves just past the acked requester whenever i_update is high.
module rggen_round_robin_arbiter #(
   parameter int REQUESTERS = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [REQUESTERS-1:0]         i_request,
   input  logic [REQUESTERS-1:0]         i_mask,
   input  logic                          i_update,
   output logic [REQUESTERS-1:0]         o_grant,
   output logic [$clog2(REQUESTERS)-1:0] o_index
);

   localparam int IDX_W = $clog2(REQUESTERS);

   logic [IDX_W-1:0]      ptr_q;
   logic [IDX_W-1:0]      mask_idx;
   logic [IDX_W-1:0]      start_idx;
   logic [REQUESTERS-1:0] req_eff;

   assign req_eff = i_request & ~i_mask;

   always_comb begin
      mask_idx = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (i_mask[i]) mask_idx = IDX_W'(i);
      end
   end

   // On an ack the new order starts just past the acked requester in the
   // same cycle, so the immediate re-arbitration is already fair.
   always_comb begin
      if (!i_update)
         start_idx = ptr_q;
      else if (mask_idx == IDX_W'(REQUESTERS - 1))
         start_idx = '0;
      else
         start_idx = mask_idx + IDX_W'(1);
   end

   always_comb begin
      logic [IDX_W-1:0] idx;
      o_grant = '0;
      o_index = '0;
      idx     = '0;
      for (int i = REQUESTERS - 1; i >= 0; i--) begin
         idx = IDX_W'((int'(start_idx) + i) % REQUESTERS);
         if (req_eff[idx]) begin
            o_grant = REQUESTERS'(1) << idx;
            o_index = idx;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         ptr_q <= '0;
      else if (i_update)
         ptr_q <= start_idx;
   end

endmodule

// File: rtl/rggen_bit_field_set_arbiter.sv
// Arbitrates hardware set requests onto a single bit-field set port.
// Optional o_blocked_count enabled by macro RGGEN_SET_ARBITER_BLOCKED_COUNT_EN.
//
// state | meaning
// IDLE  | no grant held, arbitrating incoming requests
// ISSUE | o_set driven with the registered winner value until acked
module rggen_bit_field_set_arbiter
   import rggen_bit_field_set_arbiter_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int REQUESTERS  = 2,
   parameter int WRITE_FIRST = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_sw_write,
   input  logic [REQUESTERS-1:0]       i_req,
   input  logic [REQUESTERS*WIDTH-1:0] i_req_value,
   output logic [REQUESTERS-1:0]       o_ack,
   output logic                        o_set,
   output logic [WIDTH-1:0]            o_value,
   output logic                        o_busy
`ifdef RGGEN_SET_ARBITER_BLOCKED_COUNT_EN
   ,
   output logic [BLOCKED_COUNT_WIDTH-1:0] o_blocked_count
`endif
);

   localparam int IDX_W = $clog2(REQUESTERS);

   set_arb_state_e        state_q;
   logic [IDX_W-1:0]      winner_q;
   logic [IDX_W-1:0]      gnt_idx;
   logic [REQUESTERS-1:0] gnt;
   logic [REQUESTERS-1:0] winner_oh;
   logic [REQUESTERS-1:0] arb_mask;
   logic [WIDTH-1:0]      value_q;
   logic [WIDTH-1:0]      gnt_value;
   logic                  issuing;
   logic                  blocked;
   logic                  ack_ok;

   assign issuing   = (state_q == ISSUE);
   assign blocked   = issuing && (WRITE_FIRST != 0) && i_sw_write;
   assign ack_ok    = issuing && !blocked;
   assign winner_oh = REQUESTERS'(1) << winner_q;
   assign arb_mask  = issuing ? winner_oh : '0;
   assign gnt_value = i_req_value[int'(gnt_idx)*WIDTH +: WIDTH];

   assign o_ack   = ack_ok ? winner_oh : '0;
   assign o_set   = issuing;
   assign o_busy  = issuing;
   assign o_value = value_q;

   rggen_round_robin_arbiter #(
      .REQUESTERS (REQUESTERS)
   ) u_arbiter (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_request (i_req),
      .i_mask    (arb_mask),
      .i_update  (ack_ok),
      .o_grant   (gnt),
      .o_index   (gnt_idx)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         winner_q <= '0;
         value_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|gnt) begin
                  state_q  <= ISSUE;
                  winner_q <= gnt_idx;
                  value_q  <= gnt_value;
               end
            end
            ISSUE: begin
               // A blocked cycle holds winner and value untouched.
               if (ack_ok) begin
                  if (|gnt) begin
                     winner_q <= gnt_idx;
                     value_q  <= gnt_value;
                  end else begin
                     state_q <= IDLE;
                     value_q <= '0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef RGGEN_SET_ARBITER_BLOCKED_COUNT_EN
   logic [BLOCKED_COUNT_WIDTH-1:0] blocked_count_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         blocked_count_q <= '0;
      else if (blocked && (blocked_count_q != '1))
         blocked_count_q <= blocked_count_q + BLOCKED_COUNT_WIDTH'(1);
   end

   assign o_blocked_count = blocked_count_q;
`endif

endmodule

// File: tb/tb_rggen_bit_field_set_arbiter.sv
// Bench for rggen_bit_field_set_arbiter: dut_a (2 requesters, write-first)
// and dut_b (4 requesters, set-first), checked against a scoreboard of acks.
module tb_rggen_bit_field_set_arbiter;

   typedef struct {
      int         idx;
      logic [7:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sw_a = 1'b0;
   logic [1:0]  req_a = '0;
   logic [15:0] val_a = '0;
   logic [1:0]  ack_a;
   logic        set_a;
   logic [7:0]  value_a;
   logic        busy_a;
   logic        sw_b = 1'b0;
   logic [3:0]  req_b = '0;
   logic [31:0] val_b = '0;
   logic [3:0]  ack_b;
   logic        set_b;
   logic [7:0]  value_b;
   logic        busy_b;
`ifdef RGGEN_SET_ARBITER_BLOCKED_COUNT_EN
   logic [7:0]  bc_a;
   logic [7:0]  bc_b;
`endif

   always #5 clk = ~clk;

   rggen_bit_field_set_arbiter #(.WIDTH(8), .REQUESTERS(2), .WRITE_FIRST(1)) dut_a (
      .i_clk (clk), .i_rst_n (rst_n), .i_sw_write (sw_a), .i_req (req_a),
      .i_req_value (val_a), .o_ack (ack_a), .o_set (set_a), .o_value (value_a),
      .o_busy (busy_a)
`ifdef RGGEN_SET_ARBITER_BLOCKED_COUNT_EN
      , .o_blocked_count (bc_a)
`endif
   );

   rggen_bit_field_set_arbiter #(.WIDTH(8), .REQUESTERS(4), .WRITE_FIRST(0)) dut_b (
      .i_clk (clk), .i_rst_n (rst_n), .i_sw_write (sw_b), .i_req (req_b),
      .i_req_value (val_b), .o_ack (ack_b), .o_set (set_b), .o_value (value_b),
      .o_busy (busy_b)
`ifdef RGGEN_SET_ARBITER_BLOCKED_COUNT_EN
      , .o_blocked_count (bc_b)
`endif
   );

   task automatic do_reset();
      rst_n = 1'b0;
      sw_a = 1'b0; req_a = '0; val_a = '0;
      sw_b = 1'b0; req_b = '0; val_b = '0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_a = 2'b11; req_b = 4'b1111;
      #3;
      n_cmp++;
      if ({set_a, busy_a, ack_a, value_a} !== 12'h000) begin
         n_err++; $display("FAIL reset_a act=%h exp=000", {set_a, busy_a, ack_a, value_a});
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({set_a, busy_a, ack_a} !== 4'h0) begin
         n_err++; $display("FAIL reset_a_req act=%h exp=0", {set_a, busy_a, ack_a});
      end
      n_cmp++;
      if ({set_b, busy_b, ack_b, value_b} !== 14'h0) begin
         n_err++; $display("FAIL reset_b act=%h exp=0", {set_b, busy_b, ack_b, value_b});
      end
`ifdef RGGEN_SET_ARBITER_BLOCKED_COUNT_EN
      n_cmp++;
      if (bc_a !== 8'd0) begin
         n_err++; $display("FAIL reset_count act=%0d exp=0", bc_a);
      end
`endif
      do_reset();
   endtask

   task automatic test_single();
      exp_t e;
      do_reset();
      req_a = 2'b01; val_a = 16'h3CA5;
      sb_q.push_back('{0, 8'hA5});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if (set_a !== (c == 1)) begin
            n_err++; $display("FAIL single_set c=%0d act=%b exp=%b", c, set_a, (c == 1));
         end
         if (c == 2) begin
            n_cmp++;
            if (busy_a !== 1'b0) begin
               n_err++; $display("FAIL single_busy act=%b exp=0", busy_a);
            end
         end
         if (ack_a !== 2'b00) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++; $display("FAIL single_ack unexpected act=%b", ack_a);
            end else begin
               e = sb_q.pop_front();
               if (ack_a !== (2'b01 << e.idx) || value_a !== e.val) begin
                  n_err++; $display("FAIL single_ack act=%b/%h exp=%0d/%h", ack_a, value_a, e.idx, e.val);
               end
            end
         end
         @(posedge clk);
         #1;
         req_a = req_a & ~ack_a;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++; $display("FAIL single_pending act=%0d exp=0", sb_q.size());
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      req_a = 2'b11; val_a = 16'h2211;
      sb_q.push_back('{0, 8'h11});
      sb_q.push_back('{1, 8'h22});
      sb_q.push_back('{0, 8'h11});
      sb_q.push_back('{1, 8'h22});
      for (int c = 0; c < 6; c++) begin
         if (c == 4) req_a = 2'b00;
         @(negedge clk);
         n_cmp++;
         if (set_a !== (c >= 1 && c <= 4)) begin
            n_err++; $display("FAIL b2b_set c=%0d act=%b", c, set_a);
         end
         if (ack_a !== 2'b00) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++; $display("FAIL b2b_ack unexpected act=%b", ack_a);
            end else begin
               e = sb_q.pop_front();
               if (ack_a !== (2'b01 << e.idx) || value_a !== e.val) begin
                  n_err++; $display("FAIL b2b_ack c=%0d act=%b/%h exp=%0d/%h", c, ack_a, value_a, e.idx, e.val);
               end
            end
         end
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++; $display("FAIL b2b_pending act=%0d exp=0", sb_q.size());
      end
   endtask

   task automatic test_sw_collision();
      exp_t e;
      do_reset();
      req_a = 2'b01; val_a = 16'h005A;
      sb_q.push_back('{0, 8'h5A});
      for (int c = 0; c < 6; c++) begin
         sw_a = (c >= 1 && c <= 3);
         if (c == 1) val_a = 16'h00FF;
         @(negedge clk);
         if (c >= 1 && c <= 3) begin
            n_cmp++;
            if (ack_a !== 2'b00 || value_a !== 8'h5A || set_a !== 1'b1) begin
               n_err++; $display("FAIL sw_block c=%0d act=%b/%h/%b exp=00/5a/1", c, ack_a, value_a, set_a);
            end
         end
         if (c == 4) begin
            n_cmp++;
            if (ack_a !== 2'b01) begin
               n_err++; $display("FAIL sw_release act=%b exp=01", ack_a);
            end
         end
`ifdef RGGEN_SET_ARBITER_BLOCKED_COUNT_EN
         if (c == 5) begin
            n_cmp++;
            if (bc_a !== 8'd3) begin
               n_err++; $display("FAIL sw_count act=%0d exp=3", bc_a);
            end
         end
`endif
         if (ack_a !== 2'b00) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++; $display("FAIL sw_ack unexpected act=%b", ack_a);
            end else begin
               e = sb_q.pop_front();
               if (ack_a !== (2'b01 << e.idx) || value_a !== e.val) begin
                  n_err++; $display("FAIL sw_ack act=%b/%h exp=%0d/%h", ack_a, value_a, e.idx, e.val);
               end
            end
         end
         @(posedge clk);
         #1;
         req_a = req_a & ~ack_a;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++; $display("FAIL sw_pending act=%0d exp=0", sb_q.size());
      end
   endtask

   task automatic test_write_first0();
      exp_t e;
      do_reset();
      sw_b = 1'b1; req_b = 4'b0100; val_b = 32'h0077_0000;
      sb_q.push_back('{2, 8'h77});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 1) begin
            n_cmp++;
            if (ack_b !== 4'b0100) begin
               n_err++; $display("FAIL wf0_ack act=%b exp=0100", ack_b);
            end
         end
         if (ack_b !== 4'b0000) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++; $display("FAIL wf0_sb unexpected act=%b", ack_b);
            end else begin
               e = sb_q.pop_front();
               if (ack_b !== (4'b0001 << e.idx) || value_b !== e.val) begin
                  n_err++; $display("FAIL wf0_sb act=%b/%h exp=%0d/%h", ack_b, value_b, e.idx, e.val);
               end
            end
         end
         @(posedge clk);
         #1;
         req_b = req_b & ~ack_b;
      end
      sw_b = 1'b0;
      n_cmp++;
      if (sb_q.size() != 0 || busy_b !== 1'b0) begin
         n_err++; $display("FAIL wf0_end act=%0d/%b exp=0/0", sb_q.size(), busy_b);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      do_reset();
      req_b = 4'b1111; val_b = 32'h4030_2010;
      sb_q.push_back('{0, 8'h10});
      sb_q.push_back('{1, 8'h20});
      sb_q.push_back('{2, 8'h30});
      sb_q.push_back('{3, 8'h40});
      sb_q.push_back('{0, 8'h10});
      // Second burst keeps the pointer (now past requester 0): 3 before 0.
      for (int c = 0; c < 11; c++) begin
         if (c == 5) req_b = 4'b0000;
         if (c == 7) begin
            req_b = 4'b1001;
            sb_q.push_back('{3, 8'h40});
            sb_q.push_back('{0, 8'h10});
         end
         if (c == 9) req_b = 4'b0000;
         @(negedge clk);
         if (ack_b !== 4'b0000) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++; $display("FAIL rr_ack unexpected c=%0d act=%b", c, ack_b);
            end else begin
               e = sb_q.pop_front();
               if (ack_b !== (4'b0001 << e.idx) || value_b !== e.val) begin
                  n_err++; $display("FAIL rr_ack c=%0d act=%b/%h exp=%0d/%h", c, ack_b, value_b, e.idx, e.val);
               end
            end
         end
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++; $display("FAIL rr_pending act=%0d exp=0", sb_q.size());
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      do_reset();
      req_a = 2'b10; val_a = 16'hBBAA;
      @(posedge clk);
      #1;
      n_cmp++;
      if (set_a !== 1'b1 || value_a !== 8'hBB) begin
         n_err++; $display("FAIL midrst_issue act=%b/%h exp=1/bb", set_a, value_a);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({set_a, busy_a, ack_a, value_a} !== 12'h000) begin
         n_err++; $display("FAIL midrst_async act=%h exp=000", {set_a, busy_a, ack_a, value_a});
      end
      @(posedge clk);
      #1;
      req_a = 2'b11;
      rst_n = 1'b1;
      sb_q.push_back('{0, 8'hAA});
      sb_q.push_back('{1, 8'hBB});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ack_a !== 2'b00) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++; $display("FAIL midrst_ack unexpected act=%b", ack_a);
            end else begin
               e = sb_q.pop_front();
               if (ack_a !== (2'b01 << e.idx) || value_a !== e.val) begin
                  n_err++; $display("FAIL midrst_ack act=%b/%h exp=%0d/%h", ack_a, value_a, e.idx, e.val);
               end
            end
         end
         @(posedge clk);
         #1;
         req_a = req_a & ~ack_a;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++; $display("FAIL midrst_pending act=%0d exp=0", sb_q.size());
      end
   endtask

   task automatic test_saturation();
      int bad_acks;
      bad_acks = 0;
      do_reset();
      req_a = 2'b01; val_a = 16'h0099; sw_a = 1'b1;
      for (int c = 0; c < 302; c++) begin
         @(negedge clk);
         if (ack_a !== 2'b00) bad_acks++;
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (bad_acks != 0 || set_a !== 1'b1) begin
         n_err++; $display("FAIL sat_blocked acks=%0d set=%b exp=0/1", bad_acks, set_a);
      end
`ifdef RGGEN_SET_ARBITER_BLOCKED_COUNT_EN
      n_cmp++;
      if (bc_a !== 8'd255) begin
         n_err++; $display("FAIL sat_count act=%0d exp=255", bc_a);
      end
`endif
      sw_a = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ack_a !== 2'b01 || value_a !== 8'h99) begin
         n_err++; $display("FAIL sat_release act=%b/%h exp=01/99", ack_a, value_a);
      end
      @(posedge clk);
      #1 req_a = 2'b00;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_sw_collision();
      test_write_first0();
      test_round_robin();
      test_mid_reset();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rggen_bit_field_set_arbiter.md
RGGEN_BIT_FIELD_SET_ARBITER -- requirements
Module: rggen_bit_field_set_arbiter

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8: bit-field width, legal range 1..64.
REQ-002 The module SHALL take parameter REQUESTERS, default 2: number of hardware set sources, legal range 2..16.
REQ-003 The module SHALL take parameter WRITE_FIRST, default 1: 1 means a software write overrides a set in the same cycle.
REQ-004 Port i_clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-005 Port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port i_sw_write, input, 1 bit: software write to the target field this cycle (valid AND any write-mask bit set).
REQ-007 Port i_req, input, REQUESTERS bits: per-requester set request, level, held until acked.
REQ-008 Port i_req_value, input, REQUESTERS*WIDTH bits: packed set values; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port o_ack, output, REQUESTERS bits: one-hot completion pulse.
REQ-010 Port o_set, output, 1 bit: drives the field's i_set.
REQ-011 Port o_value, output, WIDTH bits: drives the field's i_value.
REQ-012 Port o_busy, output, 1 bit: high while the FSM is in ISSUE.

Function
REQ-013 The FSM SHALL have two states, IDLE and ISSUE.
REQ-014 IDLE -> ISSUE SHALL occur when any i_req bit is set; the winner index and its i_req_value SHALL be registered on that edge.
REQ-015 In ISSUE, o_set SHALL be 1 and o_value SHALL equal the registered value, held stable for the whole stay.
REQ-016 o_ack[winner] SHALL be 1 in an ISSUE cycle iff NOT (WRITE_FIRST==1 AND i_sw_write==1); all other o_ack bits SHALL be 0.
REQ-017 A blocked ISSUE cycle (no ack) SHALL keep the FSM in ISSUE with winner and value unchanged.
REQ-018 With WRITE_FIRST==0, i_sw_write SHALL never block an ack.
REQ-019 On an acked ISSUE cycle, the FSM SHALL re-arbitrate with the winner's request masked. It SHALL go directly to ISSUE with a new winner if any other request is pending, else to IDLE.
REQ-020 Sustained throughput SHALL therefore be one set per cycle; latency from i_req rising in IDLE to o_set SHALL be 1 cycle.
REQ-021 Arbitration SHALL be round-robin: after an ack to k, priority order SHALL be k+1, k+2, ... modulo REQUESTERS.
REQ-022 i_req_value SHALL be sampled only at grant; later changes SHALL have no effect on the issued value.
REQ-023 A request withdrawn before grant SHALL be ignored; withdrawal after grant SHALL NOT cancel the issue.

Reset
REQ-024 While i_rst_n is low, the FSM SHALL be IDLE, the round-robin pointer SHALL give requester 0 highest priority, and o_set, o_value, o_ack and o_busy SHALL be 0.
REQ-025 Reset asserted during ISSUE SHALL abort it without an ack; the affected requester SHALL retry after reset.

Configuration
REQ-026 Macro RGGEN_SET_ARBITER_BLOCKED_COUNT_EN, when defined, SHALL add output o_blocked_count, 8 bits. The counter SHALL increment once per blocked ISSUE cycle, saturate at 255 and reset to 0.
REQ-027 Without RGGEN_SET_ARBITER_BLOCKED_COUNT_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 Package rggen_bit_field_set_arbiter_pkg SHALL hold the state enum typedef and the constant BLOCKED_COUNT_WIDTH = 8.
REQ-029 Sub-module rggen_round_robin_arbiter SHALL hold the priority pointer, take request, mask and update inputs, and give a one-hot grant plus index.

Verification
REQ-030 Single request: REQUESTERS=2, WIDTH=8, i_req=2'b01, value 8'hA5 -> o_set=1, o_value=8'hA5, o_ack=2'b01 on cycle 1; o_busy=0 on cycle 2.
REQ-031 Back-to-back: i_req=2'b11 continuously with values 8'h11/8'h22 -> acks alternate 01,10,01 on consecutive cycles, o_set stays 1.
REQ-032 Software collision: WRITE_FIRST=1, i_sw_write=1 for 3 ISSUE cycles -> no ack and o_value held for 3 cycles, ack on cycle 4; with the macro, o_blocked_count=3.
REQ-033 WRITE_FIRST=0 with i_sw_write=1 -> ack in the first ISSUE cycle.
REQ-034 Mid-issue reset: assert i_rst_n=0 during ISSUE -> all outputs 0 asynchronously, no ack; after release, requester 0 wins first.
REQ-035 Saturation: 300 blocked cycles with the macro -> o_blocked_count=255.
